// File: rtl/tnn_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : tnn_byte_packer
// Description : Packs compressed ternary bytes little-endian into words and
//               queues them in a small registered FIFO with byte enables.
// Revision    : 1.0 - initial release
// ============================================================================
module tnn_byte_packer #(
    parameter int BYTE_WIDTH = 8,
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic [BYTE_WIDTH-1:0]            byte_i,
    input  logic                             byte_valid_i,
    output logic                             byte_ready_o,
    input  logic                             flush_i,
    output logic [WORD_WIDTH-1:0]            word_o,
    output logic [WORD_WIDTH/BYTE_WIDTH-1:0] be_o,
    output logic                             word_valid_o,
    input  logic                             word_ready_i,
    output logic                             overflow_o,
    output logic [15:0]                      word_count_o
);

    localparam int LANES = WORD_WIDTH / BYTE_WIDTH;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(LANES - 1);
    localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);
    localparam logic [PTR_W:0]   c_ptr_one  = (PTR_W + 1)'(1);

    logic                  r_active;
    logic [IDX_W-1:0]      r_idx;
    logic [WORD_WIDTH-1:0] r_asm;
    logic [LANES-1:0]      r_be;
    logic                  r_flush_pend;
    logic                  r_overflow;
    logic [15:0]           r_word_count;
    logic [PTR_W:0]        r_wptr;
    logic [PTR_W:0]        r_rptr;
    logic [WORD_WIDTH-1:0] r_mem_word [FIFO_DEPTH];
    logic [LANES-1:0]      r_mem_be   [FIFO_DEPTH];

    logic                  w_empty;
    logic                  w_full;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_last;
    logic                  w_has_data;
    logic                  w_flush_req;
    logic                  w_partial;
    logic                  w_defer;
    logic                  w_push;
    logic [WORD_WIDTH-1:0] w_asm_next;
    logic [LANES-1:0]      w_be_next;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);

    // Readiness is a function of registered state only, so the consumer's
    // ready never reaches the compressor enable combinationally.
    assign byte_ready_o = r_active & ~r_flush_pend & ((r_idx != c_last_idx) | ~w_full);

    assign w_accept = byte_valid_i & byte_ready_o;
    assign w_pop    = ~w_empty & word_ready_i;

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            logic w_hit;
            assign w_hit = w_accept && (r_idx == IDX_W'(g));
            assign w_asm_next[g*BYTE_WIDTH +: BYTE_WIDTH] =
                w_hit ? byte_i : r_asm[g*BYTE_WIDTH +: BYTE_WIDTH];
            assign w_be_next[g] = w_hit | r_be[g];
        end
    endgenerate

    assign w_last      = w_accept && (r_idx == c_last_idx);
    assign w_has_data  = (r_idx != '0) || w_accept;
    // A flush that coincides with the last lane is absorbed by the full-word push.
    assign w_flush_req = flush_i & ~r_flush_pend & ~w_last & w_has_data;
    assign w_partial   = (w_flush_req | r_flush_pend) & ~w_full;
    assign w_defer     = w_flush_req & w_full;
    assign w_push      = w_last | w_partial;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_active     <= 1'b0;
            r_idx        <= '0;
            r_asm        <= '0;
            r_be         <= '0;
            r_flush_pend <= 1'b0;
            r_overflow   <= 1'b0;
            r_word_count <= '0;
        end else if (clear_i) begin
            r_active     <= 1'b1;
            r_idx        <= '0;
            r_asm        <= '0;
            r_be         <= '0;
            r_flush_pend <= 1'b0;
            r_overflow   <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_active <= 1'b1;
            if (byte_valid_i && !byte_ready_o) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_idx <= '0;
                r_asm <= '0;
                r_be  <= '0;
            end else if (w_accept) begin
                r_idx <= r_idx + c_idx_one;
                r_asm <= w_asm_next;
                r_be  <= w_be_next;
            end
            if (w_partial) begin
                r_flush_pend <= 1'b0;
            end else if (w_defer) begin
                r_flush_pend <= 1'b1;
            end
            if (w_pop) begin
                r_word_count <= r_word_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_word[i] <= '0;
                r_mem_be[i]   <= '0;
            end
        end else if (clear_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_mem_word[r_wptr[PTR_W-1:0]] <= w_asm_next;
                r_mem_be[r_wptr[PTR_W-1:0]]   <= w_be_next;
                r_wptr                        <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
        end
    end

    assign word_o       = w_empty ? '0 : r_mem_word[r_rptr[PTR_W-1:0]];
    assign be_o         = w_empty ? '0 : r_mem_be[r_rptr[PTR_W-1:0]];
    assign word_valid_o = ~w_empty;
    assign overflow_o   = r_overflow;
    assign word_count_o = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_tnn_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tnn_byte_packer
// Description : Directed and randomized bench for tnn_byte_packer against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tnn_byte_packer;

    localparam int LANES = 4;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  byte_d = '0;
    logic        byte_v = 1'b0;
    logic        flush = 1'b0;
    logic        word_ready = 1'b0;
    logic        byte_ready_o;
    logic [31:0] word_o;
    logic [3:0]  be_o;
    logic        word_valid_o;
    logic        overflow_o;
    logic [15:0] word_count_o;

    tnn_byte_packer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .byte_i       (byte_d),
        .byte_valid_i (byte_v),
        .byte_ready_o (byte_ready_o),
        .flush_i      (flush),
        .word_o       (word_o),
        .be_o         (be_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready),
        .overflow_o   (overflow_o),
        .word_count_o (word_count_o)
    );

    always #5 clk = ~clk;

    // Reference model: pending bytes, queued words, and status flags.
    logic [7:0]  byte_q[$];
    logic [31:0] word_q[$];
    logic [3:0]  be_q[$];
    bit          m_active = 1'b0;
    bit          m_pend   = 1'b0;
    bit          m_ovf    = 1'b0;
    logic [15:0] m_cnt    = '0;

    function automatic bit m_ready();
        return m_active && !m_pend &&
               ((byte_q.size() != LANES - 1) || (word_q.size() < DEPTH));
    endfunction

    task automatic m_reset(input bit active);
        byte_q.delete();
        word_q.delete();
        be_q.delete();
        m_pend   = 1'b0;
        m_ovf    = 1'b0;
        m_cnt    = '0;
        m_active = active;
    endtask

    task automatic m_push_partial();
        logic [31:0] w;
        w = '0;
        foreach (byte_q[k]) w[8*k +: 8] = byte_q[k];
        word_q.push_back(w);
        be_q.push_back(4'((1 << byte_q.size()) - 1));
        byte_q.delete();
    endtask

    always @(posedge clk) begin
        bit rdy;
        bit full_before;
        if (!rst_n) begin
            m_reset(1'b0);
        end else if (clear) begin
            m_reset(1'b1);
        end else begin
            rdy         = m_ready();
            full_before = (word_q.size() == DEPTH);
            if (word_q.size() > 0 && word_ready) begin
                void'(word_q.pop_front());
                void'(be_q.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (byte_v && !rdy) m_ovf = 1'b1;
            if (byte_v && rdy) byte_q.push_back(byte_d);
            if (byte_q.size() == LANES) begin
                m_push_partial();
            end else if ((flush && !m_pend && byte_q.size() > 0) || m_pend) begin
                if (!full_before) begin
                    m_push_partial();
                    m_pend = 1'b0;
                end else begin
                    m_pend = 1'b1;
                end
            end
            m_active = 1'b1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    bit          s_ready;
    bit          s_valid;
    logic [31:0] s_word;
    logic [3:0]  s_be;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_all();
        bit e_valid;
        if (!rst_n) begin
            check("rst_word_valid", word_valid_o, 0);
            check("rst_word", word_o, 0);
            check("rst_be", be_o, 0);
            check("rst_byte_ready", byte_ready_o, 0);
            check("rst_overflow", overflow_o, 0);
            check("rst_count", word_count_o, 0);
        end else begin
            e_valid = (word_q.size() > 0);
            check("word_valid", word_valid_o, e_valid);
            check("word", word_o, e_valid ? word_q[0] : 32'h0);
            check("be", be_o, e_valid ? be_q[0] : 4'h0);
            check("byte_ready", byte_ready_o, m_ready());
            check("overflow", overflow_o, m_ovf);
            check("count", word_count_o, m_cnt);
        end
    endtask

    // Every cycle: compare at the falling edge, then drive 2 time units after rising.
    task automatic tick();
        @(negedge clk);
        compare_all();
        s_ready = byte_ready_o;
        s_valid = word_valid_o;
        s_word  = word_o;
        s_be    = be_o;
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        bit got;
        got    = 1'b0;
        byte_v = 1'b1;
        byte_d = b;
        for (int i = 0; i < 50 && !got; i++) begin
            tick();
            got = s_ready;
        end
        byte_v = 1'b0;
        check("send_accepted", got, 1);
    endtask

    task automatic wait_word(input string name, input logic [31:0] w, input logic [3:0] be);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = s_valid;
        end
        check({name, "_seen"}, seen, 1);
        check({name, "_word"}, s_word, w);
        check({name, "_be"}, s_be, be);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        // Reset and release
        tick();
        tick();
        check("por_valid", word_valid_o, 0);
        check("por_ready", byte_ready_o, 0);
        rst_n = 1'b1;
        check("release_ready_before_edge", byte_ready_o, 0);
        tick();
        check("release_ready_after_edge", byte_ready_o, 1);

        // Full word with ready consumer
        word_ready = 1'b1;
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        wait_word("full", 32'h44332211, 4'hF);
        check("full_count", word_count_o, 1);

        // Partial flush, then a no-op flush
        do_clear();
        send(8'hAA); send(8'hBB); send(8'hCC);
        flush = 1'b1; tick(); flush = 1'b0;
        wait_word("partial", 32'h00CCBBAA, 4'b0111);
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (4) tick();
        check("noop_flush_count", word_count_o, 1);

        // Backpressure: two words queued, third held
        do_clear();
        word_ready = 1'b0;
        for (int i = 1; i <= 11; i++) send(8'(i));
        byte_v = 1'b1; byte_d = 8'h0C;
        tick(); tick();
        check("bp_ready_low", byte_ready_o, 0);
        check("bp_head", word_o, 32'h04030201);
        word_ready = 1'b1;
        send(8'h0C);
        repeat (6) tick();
        check("bp_count", word_count_o, 3);

        // Overflow and clear
        do_clear();
        word_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(8'h31 + i));
        send(8'h21); send(8'h22); send(8'h23);
        byte_v = 1'b1; byte_d = 8'hEE;
        tick(); tick();
        byte_v = 1'b0;
        check("ovf_set", overflow_o, 1);
        word_ready = 1'b1;
        send(8'h24);
        repeat (6) tick();
        check("ovf_count", word_count_o, 3);
        do_clear();
        check("clr_ovf", overflow_o, 0);
        check("clr_valid", word_valid_o, 0);
        check("clr_count", word_count_o, 0);

        // Flush together with the last lane
        send(8'h41); send(8'h42); send(8'h43);
        byte_v = 1'b1; byte_d = 8'h44; flush = 1'b1;
        tick();
        byte_v = 1'b0; flush = 1'b0;
        wait_word("flush_last", 32'h44434241, 4'hF);
        repeat (4) tick();
        check("flush_last_count", word_count_o, 1);

        // Partial flush with the FIFO full
        word_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(8'h51 + i));
        send(8'h61); send(8'h62);
        flush = 1'b1; tick(); flush = 1'b0;
        tick(); tick();
        check("pend_ready_low", byte_ready_o, 0);
        word_ready = 1'b1;
        repeat (6) tick();
        check("pend_count", word_count_o, 4);

        // Reset mid-word
        send(8'h01); send(8'h02);
        rst_n = 1'b0;
        #1;
        check("arst_valid", word_valid_o, 0);
        check("arst_ready", byte_ready_o, 0);
        check("arst_count", word_count_o, 0);
        check("arst_word", word_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        send(8'h55); send(8'h66); send(8'h77); send(8'h88);
        wait_word("after_rst", 32'h88776655, 4'hF);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            byte_v     = ($urandom_range(0, 3) != 0);
            byte_d     = 8'($urandom);
            flush      = ($urandom_range(0, 7) == 0);
            word_ready = ((c / 200) % 2 == 1) ? ($urandom_range(0, 3) == 0)
                                              : ($urandom_range(0, 3) != 0);
            clear      = ($urandom_range(0, 149) == 0);
            rst_n      = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst_n = 1'b1; clear = 1'b0; byte_v = 1'b0; flush = 1'b0; word_ready = 1'b1;
        repeat (6) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tnn_byte_packer.md
Name: tnn_byte_packer

Overview:
- Downstream of threshold_compress: collects its OUTPUT_WIDTH-bit compressed ternary bytes and packs them little-endian into 32-bit words for the activation write-back path.
- Output side is a 2-entry registered FIFO with a valid/ready interface.
- Handles partial words on flush (byte enables), and raises a sticky overflow flag when a byte arrives while the packer cannot take it.

Parameters:
- BYTE_WIDTH, 8, width of one compressed byte; matches threshold_compress OUTPUT_WIDTH.
- WORD_WIDTH, 32, packed output word width; must be a multiple of BYTE_WIDTH.
- FIFO_DEPTH, 2, output FIFO entries; must be a power of 2 and ≥2.
- Derived: LANES = WORD_WIDTH/BYTE_WIDTH (4 at defaults).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear of all state; highest priority after reset.
- byte_i  in  BYTE_WIDTH  compressed byte (connects to threshold_compress data_o).
- byte_valid_i  in  1  byte_i valid this cycle (connects to threshold_compress ready_o).
- byte_ready_o  out  1  packer can accept a byte this cycle; controller gates compressor enable with it.
- flush_i  in  1  single-cycle pulse: emit any partially assembled word.
- word_o  out  WORD_WIDTH  FIFO head word.
- be_o  out  LANES  byte enables of word_o; bit k covers lane k.
- word_valid_o  out  1  FIFO not empty.
- word_ready_i  in  1  consumer accepts word_o.
- overflow_o  out  1  sticky: byte_valid_i seen while byte_ready_o=0.
- word_count_o  out  16  words popped since reset/clear; wraps at 65535→0.

Behaviour:
- Reset (async, rst_ni=0):
  - Lane index = 0; assembly register and byte enables = 0.
  - FIFO empty, flush-pending = 0.
  - All outputs 0: byte_ready_o=0 while in reset, 1 on the first cycle after release.
- clear_i=1: same end state as reset at the next edge; overrides byte_valid_i, flush_i and word_ready_i that cycle (no push, no pop, no count).
- Byte accept:
  - Accept condition: byte_valid_i & byte_ready_o.
  - Byte is written to lane[idx] ([BYTE_WIDTH*idx +: BYTE_WIDTH]) and be[idx] is set; idx increments.
  - Lane 0 is the first byte received.
- Word completion:
  - On the edge that accepts the byte for lane LANES-1, the assembled word with be=all ones is pushed into the FIFO, and the assembly register, be and idx clear.
  - If the FIFO was empty, word_valid_o is high in the next cycle (1-cycle latency from last byte).
- byte_ready_o = !flush_pending & ((idx != LANES-1) | !fifo_full).
  - Depends only on registered state; no combinational path from word_ready_i.
- Flush:
  - flush_i with idx>0 (counting a byte accepted the same cycle) requests a push of the partial word. Unfilled lanes are 0 and their be bits are 0.
  - If the FIFO is not full, the push happens at that edge. Otherwise flush_pending is set, byte_ready_o is held low, and the push happens on the first edge with space.
  - flush_i with idx=0 and no byte accepted: no-op, no empty word is ever pushed.
  - flush_i on the same cycle as a lane LANES-1 byte: exactly one full word is pushed; the flush is then a no-op.
  - flush_i while flush_pending: ignored.
- FIFO:
  - Circular buffer with read/write pointers plus one extra wrap bit.
  - word_o/be_o are driven from the head entry; they are 0 when empty.
  - Pop condition: word_valid_o & word_ready_i.
  - Push and pop in the same cycle are allowed when not full. A full FIFO cannot take a push in the same cycle as a pop, because byte_ready_o is registered.
  - Order is strictly FIFO.
- word_count_o: increments on each pop.
- overflow_o: set on byte_valid_i & !byte_ready_o; the byte is dropped and state is unchanged. Cleared only by reset or clear_i.
- Reset mid-word or with a full FIFO: all data is discarded; the next byte goes to lane 0.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 on consecutive cycles, word_ready_i=1 → one cycle after the 4th byte: word_o=0x44332211, be_o=4'hF, word_valid_o for 1 cycle; word_count_o=1.
- Bytes 0xAA,0xBB,0xCC then flush_i → word_o=0x00CCBBAA, be_o=4'b0111; a second flush_i with idx=0 produces no word.
- word_ready_i=0, feed 12 bytes 0x01..0x0C with valid held → two words (0x04030201, 0x08070605) queued. byte_ready_o drops after byte 0x0B is accepted (idx=3, FIFO full) and 0x0C is held by the driver. Raise word_ready_i → words pop in order, 0x0C is accepted, and the third word 0x0C0B0A09 follows.
- Fill the FIFO, then force byte_valid_i=1 while byte_ready_o=0 → overflow_o=1, the stall-cycle byte is absent from all words; clear_i → overflow_o=0, word_valid_o=0, word_count_o=0.
- Flush on the same cycle as the 4th byte → exactly one word with be_o=4'hF. Partial flush with the FIFO full → byte_ready_o=0 until a pop, then the partial word is emitted.
- Assert rst_ni=0 after 2 bytes → all outputs 0 immediately. After release, bytes 0x55,0x66,0x77,0x88 → word_o=0x88776655.
